// File: rtl/two_d_idct.sv
// 8x8 two-dimensional inverse DCT: row pass into a transpose buffer, then column pass,
// eight MAC lanes sharing one cosine ROM. Start/done pulse handshake.
module two_d_idct #(
    parameter int COEF_FRAC = 12,
    parameter int IN_FRAC   = 6,
    parameter int MID_W     = 32
) (
    input  logic              clock,
    input  logic              rst_,
    input  logic [63:0][26:0] y,
    input  logic              IN_START,
    output logic [63:0][8:0]  x,
    output logic              OUT_XFC,
    output logic              BUSY
);
    localparam int ACC_W  = MID_W + COEF_FRAC + 4;
    localparam int CW     = COEF_FRAC + 1;
    localparam int SHIFT2 = COEF_FRAC + IN_FRAC;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PASS1 = 2'd1;
    localparam logic [1:0] PASS2 = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic signed [ACC_W-1:0] RND1    = ACC_W'(longint'(1) <<< (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] RND2    = ACC_W'(longint'(1) <<< (SHIFT2 - 1));
    localparam logic signed [ACC_W-1:0] MID_MAX = ACC_W'((longint'(1) <<< (MID_W - 1)) - longint'(1));
    localparam logic signed [ACC_W-1:0] MID_MIN = ~MID_MAX;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);
    localparam logic signed [ACC_W-1:0] PIX_MIN = ~PIX_MAX;

    // Magnitudes are 2^12 * c(k) * cos(p*pi/16); phase is folded into the first quadrant.
    function automatic logic signed [CW-1:0] cosCoef(input logic [2:0] k, input logic [2:0] n);
        int p;
        int mag;
        logic neg;
        p = ((2 * int'(n) + 1) * int'(k)) % 32;
        if (p > 16) p = 32 - p;
        neg = (p > 8);
        if (neg) p = 16 - p;
        case (p)
            0:       mag = 2048;
            1:       mag = 2009;
            2:       mag = 1892;
            3:       mag = 1703;
            4:       mag = 1448;
            5:       mag = 1138;
            6:       mag = 784;
            7:       mag = 400;
            default: mag = 0;
        endcase
        if (k == 3'd0) mag = 1448;
        return neg ? CW'(-mag) : CW'(mag);
    endfunction

    function automatic logic signed [MID_W-1:0] satMid(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + RND1) >>> COEF_FRAC;
        if (r > MID_MAX) r = MID_MAX;
        else if (r < MID_MIN) r = MID_MIN;
        return MID_W'(r);
    endfunction

    function automatic logic signed [8:0] satPix(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + RND2) >>> SHIFT2;
        if (r > PIX_MAX) r = PIX_MAX;
        else if (r < PIX_MIN) r = PIX_MIN;
        return 9'(r);
    endfunction

    logic [1:0]              state_q, state_d;
    logic [6:0]              cnt_q, cnt_d;
    logic [63:0][26:0]       yLat_q;
    logic [63:0][MID_W-1:0]  tBuf_q;
    logic signed [ACC_W-1:0] acc_q [8];
    logic signed [ACC_W-1:0] prod [8];
    logic signed [MID_W-1:0] opnd;
    logic [63:0][8:0]        xStage_q, xStage_d, x_q;
    logic                    wrT_q, wrX_q;
    logic [2:0]              wrIdx_q;
    logic [2:0]              kIdx, hiIdx;
    logic                    accEn, finish;

    assign kIdx    = cnt_q[2:0];
    assign hiIdx   = cnt_q[5:3];
    assign accEn   = (state_q == PASS1) || ((state_q == PASS2) && !cnt_q[6]);
    assign finish  = (state_q == PASS2) && cnt_q[6];
    assign x       = x_q;
    assign OUT_XFC = (state_q == DONE);
    assign BUSY    = (state_q != IDLE);

    // Every lane sees the same operand each cycle; only the cosine differs per lane.
    always_comb begin
        if (state_q == PASS1) opnd = MID_W'($signed(yLat_q[{hiIdx, kIdx}]));
        else                  opnd = $signed(tBuf_q[{kIdx, hiIdx}]);
        for (int l = 0; l < 8; l++) begin
            prod[l] = ACC_W'(opnd) * ACC_W'(cosCoef(kIdx, 3'(l)));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 7'd1;
        case (state_q)
            IDLE: begin
                cnt_d = 7'd0;
                if (IN_START) state_d = PASS1;
            end
            PASS1: begin
                if (cnt_q == 7'd63) begin
                    state_d = PASS2;
                    cnt_d   = 7'd0;
                end
            end
            PASS2: begin
                if (finish) state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 7'd0;
            end
        endcase
    end

    // Results land one cycle after their last product, so the final column goes out via the merge.
    always_comb begin
        xStage_d = xStage_q;
        if (wrX_q) begin
            for (int m = 0; m < 8; m++) begin
                xStage_d[{m[2:0], wrIdx_q}] = satPix(acc_q[m]);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            cnt_q    <= 7'd0;
            yLat_q   <= '0;
            tBuf_q   <= '0;
            xStage_q <= '0;
            x_q      <= '0;
            wrT_q    <= 1'b0;
            wrX_q    <= 1'b0;
            wrIdx_q  <= 3'd0;
            for (int l = 0; l < 8; l++) acc_q[l] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            xStage_q <= xStage_d;
            wrT_q    <= (state_q == PASS1) && (kIdx == 3'd7);
            wrX_q    <= (state_q == PASS2) && !cnt_q[6] && (kIdx == 3'd7);
            wrIdx_q  <= hiIdx;
            if ((state_q == IDLE) && IN_START) yLat_q <= y;
            if (finish) x_q <= xStage_d;
            for (int l = 0; l < 8; l++) begin
                if (accEn) acc_q[l] <= (kIdx == 3'd0) ? prod[l] : acc_q[l] + prod[l];
                if (wrT_q) tBuf_q[{wrIdx_q, l[2:0]}] <= satMid(acc_q[l]);
            end
        end
    end
endmodule

// File: tb/tb_two_d_idct.sv
// Bench for two_d_idct: real-valued reference transforms, a scoreboard of expected
// blocks, a vector table and hand-written handshake/reset sequences.
module tb_two_d_idct;
    typedef struct {
        logic [63:0][26:0] yv;
        logic [63:0][8:0]  xe;
        int                tol;
    } vec_t;

    logic              clock = 1'b0;
    logic              rst_;
    logic [63:0][26:0] y;
    logic              IN_START;
    logic [63:0][8:0]  x;
    logic              OUT_XFC;
    logic              BUSY;

    int   total = 0;
    int   bad = 0;
    int   xfcCount = 0;
    vec_t sbQ[$];
    vec_t vecs[5];
    real  basis[8][8];

    always #5 clock = ~clock;

    two_d_idct dut (
        .clock(clock), .rst_(rst_), .y(y), .IN_START(IN_START),
        .x(x), .OUT_XFC(OUT_XFC), .BUSY(BUSY)
    );

    function automatic void initBasis();
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++)
                basis[k][n] = ((k == 0) ? $sqrt(0.125) : 0.5) *
                              $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    endfunction

    function automatic logic [63:0][8:0] idctModel(input logic [63:0][26:0] yIn);
        logic [63:0][8:0] res;
        real s;
        int r;
        for (int m = 0; m < 8; m++)
            for (int n = 0; n < 8; n++) begin
                s = 0.0;
                for (int u = 0; u < 8; u++)
                    for (int v = 0; v < 8; v++)
                        s += basis[u][m] * basis[v][n] * real'($signed(yIn[8 * u + v]));
                r = $rtoi($floor(s / 64.0 + 0.5));
                if (r > 255) r = 255;
                if (r < -256) r = -256;
                res[8 * m + n] = 9'(r);
            end
        return res;
    endfunction

    function automatic logic [63:0][26:0] fdctModel(input int samp[64]);
        logic [63:0][26:0] res;
        real s;
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                s = 0.0;
                for (int m = 0; m < 8; m++)
                    for (int n = 0; n < 8; n++)
                        s += basis[u][m] * basis[v][n] * real'(samp[8 * m + n]);
                res[8 * u + v] = 27'($rtoi($floor(s * 64.0 + 0.5)));
            end
        return res;
    endfunction

    function automatic logic [63:0][8:0] fillPix(input int val);
        logic [63:0][8:0] res;
        for (int i = 0; i < 64; i++) res[i] = 9'(val);
        return res;
    endfunction

    task automatic randomBlock(output logic [63:0][26:0] yOut, output logic [63:0][8:0] xOut);
        int samp[64];
        for (int i = 0; i < 64; i++) begin
            samp[i] = int'($urandom_range(511, 0)) - 256;
            xOut[i] = 9'(samp[i]);
        end
        yOut = fdctModel(samp);
    endtask

    task automatic checkEq(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic checkOutput(input vec_t e);
        int worst = -1;
        int d;
        for (int i = 0; i < 64; i++) begin
            d = int'($signed(x[i])) - int'($signed(e.xe[i]));
            if ((d > e.tol || d < -e.tol) && worst < 0) worst = i;
        end
        total++;
        if (worst >= 0) begin
            bad++;
            $display("[TB] FAIL block_x: x[%0d]=%0d, required %0d (+/-%0d)", worst,
                     $signed(x[worst]), $signed(e.xe[worst]), e.tol);
        end
    endtask

    // Called just after a rising edge; the start is sampled on the following edge.
    task automatic applyStimulus(input logic [63:0][26:0] yIn, input logic [63:0][8:0] xe,
                                 input int tol);
        vec_t e;
        e.yv = yIn;
        e.xe = xe;
        e.tol = tol;
        sbQ.push_back(e);
        y = yIn;
        IN_START = 1'b1;
        @(posedge clock);
        #1 IN_START = 1'b0;
    endtask

    task automatic waitIdle(input int limit, input string name);
        for (int i = 0; i < limit && (sbQ.size() != 0 || BUSY); i++) begin
            @(posedge clock);
            #1;
        end
        if (sbQ.size() != 0 || BUSY) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: pending=%0d BUSY=%0b, required 0 and 0", name,
                     sbQ.size(), BUSY);
            sbQ.delete();
        end
    endtask

    always @(negedge clock) begin
        if (OUT_XFC) begin
            xfcCount++;
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_xfc: got OUT_XFC=1, required 0");
            end else begin
                checkOutput(sbQ.pop_front());
            end
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0][26:0] yA, yB, yT;
        logic [63:0][8:0]  xA, xB;
        int xfcBefore;

        initBasis();
        rst_ = 1'b0;
        IN_START = 1'b0;
        y = '0;
        repeat (3) @(posedge clock);
        #1;
        checkEq("reset_x_zero", longint'(x == '0), 1);
        checkEq("reset_xfc", OUT_XFC, 0);
        checkEq("reset_busy", BUSY, 0);
        rst_ = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] zero block with latency check");
        applyStimulus('0, fillPix(0), 0);
        for (int i = 1; i <= 131; i++) begin
            @(posedge clock);
            #1;
            if (i == 64)  checkEq("lat_busy_mid", BUSY, 1);
            if (i == 128) checkEq("lat_xfc_early", OUT_XFC, 0);
            if (i == 129) checkEq("lat_xfc", OUT_XFC, 1);
            if (i == 129) checkEq("lat_busy_done", BUSY, 1);
            if (i == 130) checkEq("lat_xfc_after", OUT_XFC, 0);
            if (i == 130) checkEq("lat_busy_after", BUSY, 0);
        end

        $display("[TB] vector table");
        yT = '0; yT[0] = 27'sd51200;
        vecs[0] = '{yT, fillPix(100), 1};
        yT = '0; yT[0] = -27'sd131072;
        vecs[1] = '{yT, fillPix(-256), 0};
        yT = '0; yT[0] = 27'sd33554432;
        vecs[2] = '{yT, fillPix(255), 0};
        yT = '0; yT[1] = 27'sd12800; yT[8] = -27'sd6400; yT[9] = 27'sd3200; yT[63] = 27'sd1000;
        vecs[3] = '{yT, idctModel(yT), 1};
        yT = '0; yT[0] = -27'sd33554432;
        vecs[4] = '{yT, fillPix(-256), 0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].yv, vecs[i].xe, vecs[i].tol);
            waitIdle(200, "table");
        end
        repeat (20) @(posedge clock);
        #1;
        checkEq("x_hold", longint'(x == vecs[4].xe), 1);

        $display("[TB] start pulses while busy and in the done cycle");
        randomBlock(yA, xA);
        randomBlock(yB, xB);
        xfcBefore = xfcCount;
        applyStimulus(yA, xA, 2);
        for (int i = 1; i <= 140; i++) begin
            IN_START = (i == 10 || i == 70 || i == 130);
            y = (i >= 5) ? yB : yA;
            @(posedge clock);
            #1;
        end
        IN_START = 1'b0;
        checkEq("ignore_single_xfc", xfcCount - xfcBefore, 1);
        checkEq("ignore_busy_low", BUSY, 0);

        $display("[TB] asynchronous reset in the column pass");
        randomBlock(yA, xA);
        applyStimulus(yA, xA, 2);
        repeat (99) @(posedge clock);
        #2 rst_ = 1'b0;
        #1;
        checkEq("abort_x_zero", longint'(x == '0), 1);
        checkEq("abort_busy", BUSY, 0);
        checkEq("abort_xfc", OUT_XFC, 0);
        void'(sbQ.pop_back());
        xfcBefore = xfcCount;
        @(posedge clock);
        #2 rst_ = 1'b1;
        repeat (200) @(posedge clock);
        #1;
        checkEq("abort_no_xfc", xfcCount - xfcBefore, 0);
        randomBlock(yB, xB);
        applyStimulus(yB, xB, 2);
        waitIdle(200, "after_reset");

        $display("[TB] 100 random blocks back to back");
        xfcBefore = xfcCount;
        for (int b = 0; b < 100; b++) begin
            randomBlock(yA, xA);
            applyStimulus(yA, xA, 2);
            if (b < 99) begin
                repeat (130) @(posedge clock);
                #1;
            end
        end
        waitIdle(300, "b2b");
        checkEq("b2b_count", xfcCount - xfcBefore, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/two_d_idct.md
Name: two_d_idct

Overview:
- 8x8 two-dimensional inverse DCT: the decode-side counterpart of the TwoDDCT forward transform.
- Accepts a 64-coefficient block in the same 27-bit signed format and reconstructs a 64-sample 9-bit signed block.
- Separable row/column engine: 8 parallel MACs, a shared cosine ROM and a transpose buffer.
- Start/done handshake matches the forward block (one-cycle start pulse in, one-cycle completion pulse out).

Parameters:
- COEF_FRAC, 12, fractional bits of cosine ROM entries; C[k][n] = round(2^COEF_FRAC * c(k) * cos((2n+1)k*pi/16)), c(0)=sqrt(1/8), c(k>0)=1/2.
- IN_FRAC, 6, fractional bits of input coefficients (Y_true = y / 2^IN_FRAC).
- MID_W, 32, width of intermediate transpose-buffer words.

Ports:
- clock, input, 1, single clock; all state on rising edge.
- rst_, input, 1, asynchronous active-low reset.
- y, input, [63:0][26:0] signed, coefficient block; index 8*u+v (u = vertical frequency, v = horizontal frequency).
- IN_START, input, 1, one-cycle start pulse; y is sampled on the same edge.
- x, output, [63:0][8:0] signed, reconstructed samples; index 8*m+n (m = row, n = column).
- OUT_XFC, output, 1, one-cycle pulse; x is valid and held from this cycle on.
- BUSY, output, 1, high from the start edge until the OUT_XFC cycle, inclusive.

Behaviour:
- Reset (rst_ low, asynchronous):
  - state=IDLE; x=0; OUT_XFC=0; BUSY=0; counters, coefficient latch and transpose buffer cleared.
- States: IDLE -> PASS1 -> PASS2 -> DONE -> IDLE.
- IDLE:
  - On IN_START=1: latch all 64 y words, set BUSY=1, cnt=0, go to PASS1.
- PASS1 (64 cycles, cnt 0..63):
  - u=cnt[5:3], k=cnt[2:0].
  - MAC lane n accumulates Y[u][k]*C[k][n].
  - At k=7, write T[u][n] = round_half_up(acc / 2^COEF_FRAC), saturated to MID_W signed, for all 8 lanes.
  - Accumulators clear at k=0.
- PASS2 (64 cycles):
  - n=cnt[5:3], k=cnt[2:0].
  - Lane m accumulates C[k][m]*T[k][n].
  - At k=7, x[8*m+n] = round_half_up(acc / 2^(COEF_FRAC+IN_FRAC)), saturated to [-256,255].
- DONE (1 cycle):
  - OUT_XFC=1, BUSY=1; next state IDLE.
- Latency:
  - IN_START sampled at edge E0; OUT_XFC is high in the cycle after edge E0+129.
  - Next IN_START is accepted in the cycle after DONE; back-to-back throughput is 1 block per 131 cycles.
- Arithmetic:
  - Products are 27x13 signed; accumulators are at least 43 bits; no overflow is possible before saturation.
  - Rounding is add 2^(s-1) then arithmetic shift right.
- Output update rules:
  - x updates only at the DONE transition; it is never partially updated.
  - x holds its last value between blocks.
- IN_START while BUSY=1: ignored, no re-latch, no effect on the current block.
- IN_START in the DONE cycle: ignored.
- y changing after the start edge has no effect.
- Reset mid-operation: block is aborted immediately; no OUT_XFC for it; x returns to 0.
- OUT_XFC never asserts more than once per accepted IN_START.

Test Plan:
- All y=0, pulse IN_START -> OUT_XFC exactly 130 cycles after the start edge; all 64 x = 0; BUSY low the cycle after.
- y[0]=51200 (DC 800 << 6), other y=0 -> all x = 100 (+/-1).
- y[0]=-131072, other y=0 -> all x = -256. Then y[0]=33554432 -> all x = 255 (saturation), no wrap.
- Random 9-bit block passed through TwoDDCT, output fed here -> every x within +/-2 of the original sample; 100 blocks back-to-back at 131-cycle spacing.
- IN_START pulses at cycles 10 and 70 after an accepted start, with y changed in between -> single OUT_XFC; x matches the first y only.
- rst_ driven low asynchronously mid-PASS2 (cycle 100) -> x=0, BUSY=0 immediately, no OUT_XFC; a new block started after reset completes correctly.
